// File: rtl/dmi_arb_pkg.sv
// Shared DMI field widths, op/response codes, arbiter state encoding and
// the packed request/response payloads used by the arbiter.
package dmi_arb_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;

  localparam logic [OP_W-1:0] OP_NOP   = 2'd0;
  localparam logic [OP_W-1:0] OP_READ  = 2'd1;
  localparam logic [OP_W-1:0] OP_WRITE = 2'd2;

  localparam logic [RESP_W-1:0] RESP_SUCCESS = 2'd0;
  localparam logic [RESP_W-1:0] RESP_FAILED  = 2'd2;
  localparam logic [RESP_W-1:0] RESP_BUSY    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETURN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DATA_W-1:0] data;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_rr_grant.sv
// Two-way round-robin pick: a lone eligible requester wins; on a tie the
// requester that was not granted last wins.
module dmi_rr_grant (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] grant_c,
  output logic       grant_idx_c
);

  always_comb begin
    grant_c     = 2'b00;
    grant_idx_c = 1'b0;
    case (eligible)
      2'b01: begin
        grant_c     = 2'b01;
        grant_idx_c = 1'b0;
      end
      2'b10: begin
        grant_c     = 2'b10;
        grant_idx_c = 1'b1;
      end
      2'b11: begin
        grant_idx_c = ~last_grant;
        grant_c     = last_grant ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Two-requester DMI arbiter: one transaction outstanding at a time, with a
// response timeout that drains the late downstream response before re-arming.
module dmi_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_bits_addr,
  input  logic [OP_W-1:0]   m0_req_bits_op,
  input  logic [DATA_W-1:0] m0_req_bits_data,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [RESP_W-1:0] m0_resp_bits_resp,
  output logic [DATA_W-1:0] m0_resp_bits_data,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_bits_addr,
  input  logic [OP_W-1:0]   m1_req_bits_op,
  input  logic [DATA_W-1:0] m1_req_bits_data,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [RESP_W-1:0] m1_resp_bits_resp,
  output logic [DATA_W-1:0] m1_resp_bits_data,

  input  logic [1:0]        m_disable,

  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [ADDR_W-1:0] dmi_req_bits_addr,
  output logic [OP_W-1:0]   dmi_req_bits_op,
  output logic [DATA_W-1:0] dmi_req_bits_data,
  input  logic              dmi_resp_valid,
  output logic              dmi_resp_ready,
  input  logic [RESP_W-1:0] dmi_resp_bits_resp,
  input  logic [DATA_W-1:0] dmi_resp_bits_data,

  output logic              busy
);

  // Counter only needs to reach TIMEOUT-1; it saturates at all-ones otherwise.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e           state;
  logic             owner;
  logic             last_grant;
  logic             drain_pending;
  logic [CNT_W-1:0] cnt;
  dmi_req_t         req_q;
  dmi_resp_t        resp_q;

  logic [1:0] eligible;
  logic [1:0] grant_c;
  logic       grant_idx_c;
  logic       take_c;
  logic       owner_resp_ready_c;
  dmi_req_t   m0_req;
  dmi_req_t   m1_req;

  assign eligible = {m1_req_valid & ~m_disable[1], m0_req_valid & ~m_disable[0]};
  assign m0_req   = '{addr: m0_req_bits_addr, op: m0_req_bits_op, data: m0_req_bits_data};
  assign m1_req   = '{addr: m1_req_bits_addr, op: m1_req_bits_op, data: m1_req_bits_data};

  dmi_rr_grant u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Acceptance is combinational; gated by reset so nothing is accepted in reset.
  assign take_c             = reset_n && (state == ST_IDLE) && (|grant_c);
  assign m0_req_ready       = take_c & grant_c[0];
  assign m1_req_ready       = take_c & grant_c[1];
  assign owner_resp_ready_c = owner ? m1_resp_ready : m0_resp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      drain_pending <= 1'b0;
      cnt           <= '0;
      req_q         <= '0;
      resp_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant_c) begin
            req_q      <= grant_idx_c ? m1_req : m0_req;
            owner      <= grant_idx_c;
            last_grant <= grant_idx_c;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dmi_req_ready) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real response wins over a timeout landing in the same cycle.
          if (dmi_resp_valid) begin
            resp_q <= '{resp: dmi_resp_bits_resp, data: dmi_resp_bits_data};
            cnt    <= '0;
            state  <= ST_RETURN;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            resp_q        <= '{resp: RESP_FAILED, data: '0};
            drain_pending <= 1'b1;
            cnt           <= '0;
            state         <= ST_RETURN;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RETURN: begin
          if (owner_resp_ready_c) begin
            state <= drain_pending ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (dmi_resp_valid) begin
            drain_pending <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dmi_req_valid     = (state == ST_ISSUE);
  assign dmi_req_bits_addr = req_q.addr;
  assign dmi_req_bits_op   = req_q.op;
  assign dmi_req_bits_data = req_q.data;
  assign dmi_resp_ready    = (state == ST_WAIT) || (state == ST_DRAIN);

  assign m0_resp_valid     = (state == ST_RETURN) && !owner;
  assign m1_resp_valid     = (state == ST_RETURN) && owner;
  assign m0_resp_bits_resp = resp_q.resp;
  assign m0_resp_bits_data = resp_q.data;
  assign m1_resp_bits_resp = resp_q.resp;
  assign m1_resp_bits_data = resp_q.data;

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_dmi_arbiter;
  import dmi_arb_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic [6:0]  m0_req_bits_addr;
  logic [1:0]  m0_req_bits_op, m0_resp_bits_resp;
  logic [31:0] m0_req_bits_data, m0_resp_bits_data;
  logic        m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  logic [6:0]  m1_req_bits_addr;
  logic [1:0]  m1_req_bits_op, m1_resp_bits_resp;
  logic [31:0] m1_req_bits_data, m1_resp_bits_data;
  logic [1:0]  m_disable;
  logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [6:0]  dmi_req_bits_addr;
  logic [1:0]  dmi_req_bits_op, dmi_resp_bits_resp;
  logic [31:0] dmi_req_bits_data, dmi_resp_bits_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last;  // model: index of the requester granted last

  always #5 clk = ~clk;

  dmi_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_bits_addr(m0_req_bits_addr), .m0_req_bits_op(m0_req_bits_op),
    .m0_req_bits_data(m0_req_bits_data), .m0_resp_valid(m0_resp_valid),
    .m0_resp_ready(m0_resp_ready), .m0_resp_bits_resp(m0_resp_bits_resp),
    .m0_resp_bits_data(m0_resp_bits_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_bits_addr(m1_req_bits_addr), .m1_req_bits_op(m1_req_bits_op),
    .m1_req_bits_data(m1_req_bits_data), .m1_resp_valid(m1_resp_valid),
    .m1_resp_ready(m1_resp_ready), .m1_resp_bits_resp(m1_resp_bits_resp),
    .m1_resp_bits_data(m1_resp_bits_data),
    .m_disable(m_disable),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_bits_addr(dmi_req_bits_addr), .dmi_req_bits_op(dmi_req_bits_op),
    .dmi_req_bits_data(dmi_req_bits_data), .dmi_resp_valid(dmi_resp_valid),
    .dmi_resp_ready(dmi_resp_ready), .dmi_resp_bits_resp(dmi_resp_bits_resp),
    .dmi_resp_bits_data(dmi_resp_bits_data),
    .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req_valid = 0; m0_req_bits_addr = '0; m0_req_bits_op = '0; m0_req_bits_data = '0;
    m1_req_valid = 0; m1_req_bits_addr = '0; m1_req_bits_op = '0; m1_req_bits_data = '0;
    m0_resp_ready = 0; m1_resp_ready = 0; m_disable = 2'b00;
    dmi_req_ready = 0; dmi_resp_valid = 0; dmi_resp_bits_resp = '0; dmi_resp_bits_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) cyc();
    reset_n = 1;
    model_last = 1'b1;
    cyc();
  endtask

  task automatic rand_reqs();
    m0_req_bits_addr = 7'($urandom); m0_req_bits_op = 2'($urandom_range(0, 2));
    m0_req_bits_data = $urandom;
    m1_req_bits_addr = 7'($urandom); m1_req_bits_op = 2'($urandom_range(0, 2));
    m1_req_bits_data = $urandom;
  endtask

  task automatic test_reset();
    logic [6:0]   outs;
    logic [108:0] fields;
    reset_n = 0;
    clear_inputs();
    m0_req_valid = 1; m1_req_valid = 1; dmi_req_ready = 1; dmi_resp_valid = 1;
    repeat (2) cyc();
    @(negedge clk);
    outs = {m0_req_ready, m1_req_ready, dmi_req_valid, dmi_resp_ready,
            m0_resp_valid, m1_resp_valid, busy};
    fields = {dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data, m0_resp_bits_resp,
              m0_resp_bits_data, m1_resp_bits_resp, m1_resp_bits_data};
    n_checks++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000000", outs);
    end
    n_checks++;
    if (fields !== '0) begin
      n_fail++; $display("FAIL reset_fields: got %0h expected 0", fields);
    end
    clear_inputs();
    reset_n = 1;
    model_last = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    m0_req_valid = 1; m0_req_bits_addr = 7'h11; m0_req_bits_op = OP_READ; m0_req_bits_data = '0;
    @(negedge clk);
    n_checks++;
    if ({m1_req_ready, m0_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL read_grant: got %b expected 01", {m1_req_ready, m0_req_ready});
    end
    model_last = 1'b0;
    cyc();
    m0_req_valid = 0; dmi_req_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_op} !== {1'b1, 7'h11, OP_READ}) begin
      n_fail++; $display("FAIL read_issue: got v=%b a=%0h op=%0d expected v=1 a=11 op=1",
                         dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_op);
    end
    cyc();
    dmi_req_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({dmi_resp_ready, busy, m0_resp_valid} !== 3'b110) begin
      n_fail++; $display("FAIL read_wait: got rr/busy/rv=%b expected 110",
                         {dmi_resp_ready, busy, m0_resp_valid});
    end
    cyc();
    dmi_resp_valid = 1; dmi_resp_bits_resp = RESP_SUCCESS; dmi_resp_bits_data = 32'hCAFE0001;
    cyc();
    dmi_resp_valid = 0; m0_resp_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({m0_resp_valid, m1_resp_valid, m0_resp_bits_resp, m0_resp_bits_data} !==
        {1'b1, 1'b0, RESP_SUCCESS, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL read_resp: got v0=%b v1=%b r=%0d d=%h expected v0=1 v1=0 r=0 d=cafe0001",
                         m0_resp_valid, m1_resp_valid, m0_resp_bits_resp, m0_resp_bits_data);
    end
    cyc();
    m0_resp_ready = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL read_idle: busy got %b expected 0", busy);
    end
    cyc();
  endtask

  task automatic test_tie();
    logic [6:0] exp_q[$];
    logic [6:0] ea;
    int grants;
    bit exp_idx;
    grants = 0;
    do_reset();
    m0_req_valid = 1; m1_req_valid = 1; dmi_req_ready = 1; dmi_resp_valid = 1;
    m0_resp_ready = 1; m1_resp_ready = 1;
    for (int c = 0; c < 60; c++) begin
      rand_reqs();
      dmi_resp_bits_data = $urandom;
      @(negedge clk);
      if (m0_req_ready || m1_req_ready) begin
        exp_idx = ~model_last;
        n_checks++;
        if ({m1_req_ready, m0_req_ready} !== (exp_idx ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL tie_grant: got %b expected m%0d", {m1_req_ready, m0_req_ready}, exp_idx);
        end
        exp_q.push_back(exp_idx ? m1_req_bits_addr : m0_req_bits_addr);
        model_last = exp_idx;
        grants++;
      end
      if (dmi_req_valid && dmi_req_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL tie_addr: got issue a=%0h expected none", dmi_req_bits_addr);
        end else begin
          ea = exp_q.pop_front();
          if (dmi_req_bits_addr !== ea) begin
            n_fail++; $display("FAIL tie_addr: got %0h expected %0h", dmi_req_bits_addr, ea);
          end
        end
      end
      cyc();
    end
    n_checks++;
    if (grants < 12) begin
      n_fail++; $display("FAIL tie_count: got %0d grants expected >= 12", grants);
    end
    m0_req_valid = 0; m1_req_valid = 0;
    repeat (5) cyc();
    clear_inputs();
    cyc();
  endtask

  task automatic test_backpressure();
    logic [40:0] ef;
    bit exp_idx;
    m0_req_valid = 1; m1_req_valid = 1;
    rand_reqs();
    @(negedge clk);
    exp_idx = ~model_last;
    n_checks++;
    if ({m1_req_ready, m0_req_ready} !== (exp_idx ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL bp_grant: got %b expected m%0d", {m1_req_ready, m0_req_ready}, exp_idx);
    end
    model_last = exp_idx;
    ef = exp_idx ? {m1_req_bits_addr, m1_req_bits_op, m1_req_bits_data}
                 : {m0_req_bits_addr, m0_req_bits_op, m0_req_bits_data};
    cyc();
    for (int i = 0; i < 5; i++) begin
      rand_reqs();
      @(negedge clk);
      n_checks++;
      if ({dmi_req_valid, m0_req_ready, m1_req_ready,
           dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data} !== {3'b100, ef}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v/r0/r1=%b f=%0h expected 100 f=%0h", i,
                           {dmi_req_valid, m0_req_ready, m1_req_ready},
                           {dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data}, ef);
      end
      cyc();
    end
    m0_req_valid = 0; m1_req_valid = 0; dmi_req_ready = 1;
    cyc();
    dmi_req_ready = 0; dmi_resp_valid = 1;
    dmi_resp_bits_resp = RESP_BUSY; dmi_resp_bits_data = $urandom;
    cyc();
    dmi_resp_valid = 0;
    if (exp_idx) m1_resp_ready = 1; else m0_resp_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({m1_resp_valid, m0_resp_valid} !== (exp_idx ? 2'b10 : 2'b01) ||
        (exp_idx ? m1_resp_bits_data : m0_resp_bits_data) !== dmi_resp_bits_data) begin
      n_fail++; $display("FAIL bp_resp: got v=%b d0=%h d1=%h expected m%0d d=%h",
                         {m1_resp_valid, m0_resp_valid}, m0_resp_bits_data, m1_resp_bits_data,
                         exp_idx, dmi_resp_bits_data);
    end
    cyc();
    clear_inputs();
    cyc();
  endtask

  task automatic test_timeout();
    logic [6:0]  na;
    logic [31:0] nd;
    m1_req_valid = 1; rand_reqs();
    @(negedge clk);
    n_checks++;
    if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL to_grant: got %b expected 10", {m1_req_ready, m0_req_ready});
    end
    model_last = 1'b1;
    cyc();
    m1_req_valid = 0; dmi_req_ready = 1;
    cyc();
    dmi_req_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({m1_resp_valid, dmi_resp_ready} !== 2'b01) begin
        n_fail++; $display("FAIL to_wait%0d: got rv/rr=%b expected 01", k, {m1_resp_valid, dmi_resp_ready});
      end
      cyc();
    end
    m1_resp_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({m1_resp_valid, m0_resp_valid, m1_resp_bits_resp, m1_resp_bits_data} !==
        {2'b10, RESP_FAILED, 32'h0}) begin
      n_fail++; $display("FAIL to_resp: got v1=%b v0=%b r=%0d d=%h expected v1=1 v0=0 r=2 d=0",
                         m1_resp_valid, m0_resp_valid, m1_resp_bits_resp, m1_resp_bits_data);
    end
    cyc();
    m1_resp_ready = 0; m1_req_valid = 1; rand_reqs();
    na = m1_req_bits_addr;
    @(negedge clk);
    n_checks++;
    if ({busy, dmi_resp_ready, m1_req_ready, m1_resp_valid} !== 4'b1100) begin
      n_fail++; $display("FAIL to_drain: got busy/rr/qr/rv=%b expected 1100",
                         {busy, dmi_resp_ready, m1_req_ready, m1_resp_valid});
    end
    cyc();
    dmi_resp_valid = 1; dmi_resp_bits_resp = RESP_SUCCESS; dmi_resp_bits_data = 32'h1234;
    @(negedge clk);
    n_checks++;
    if (m1_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL to_drain_ready: got %b expected 0", m1_req_ready);
    end
    cyc();
    dmi_resp_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL to_next_grant: got %b expected 10", {m1_req_ready, m0_req_ready});
    end
    cyc();
    m1_req_valid = 0; dmi_req_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({dmi_req_valid, dmi_req_bits_addr} !== {1'b1, na}) begin
      n_fail++; $display("FAIL to_next_issue: got v=%b a=%0h expected v=1 a=%0h",
                         dmi_req_valid, dmi_req_bits_addr, na);
    end
    cyc();
    nd = $urandom | 32'h1;
    dmi_req_ready = 0; dmi_resp_valid = 1; dmi_resp_bits_data = nd;
    cyc();
    dmi_resp_valid = 0; m1_resp_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({m1_resp_valid, m1_resp_bits_resp, m1_resp_bits_data} !== {1'b1, RESP_SUCCESS, nd}) begin
      n_fail++; $display("FAIL to_next_resp: got v=%b r=%0d d=%h expected v=1 r=0 d=%h",
                         m1_resp_valid, m1_resp_bits_resp, m1_resp_bits_data, nd);
    end
    cyc();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL to_idle: busy got %b expected 0", busy);
    end
    cyc();
  endtask

  task automatic test_disable_reset();
    logic [6:0]   outs;
    logic [108:0] fields;
    int grants;
    grants = 0;
    m_disable = 2'b01; m0_req_valid = 1; m1_req_valid = 1;
    dmi_req_ready = 1; dmi_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
    for (int c = 0; c < 24; c++) begin
      rand_reqs();
      @(negedge clk);
      n_checks++;
      if (m0_req_ready !== 1'b0 || m0_resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL dis_m0: got qr=%b rv=%b expected 0 0", m0_req_ready, m0_resp_valid);
      end
      if (m1_req_ready) begin
        grants++;
        model_last = 1'b1;
      end
      cyc();
    end
    n_checks++;
    if (grants < 4) begin
      n_fail++; $display("FAIL dis_count: got %0d m1 grants expected >= 4", grants);
    end
    m0_req_valid = 0; m1_req_valid = 0;
    repeat (5) cyc();
    clear_inputs();
    m_disable = 2'b01; m1_req_valid = 1;
    cyc();
    m1_req_valid = 0; dmi_req_ready = 1;
    cyc();
    dmi_req_ready = 0;
    cyc();
    m0_req_valid = 1; m1_req_valid = 1; m_disable = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({busy, dmi_resp_ready} !== 2'b11) begin
      n_fail++; $display("FAIL dis_in_wait: got busy/rr=%b expected 11", {busy, dmi_resp_ready});
    end
    #2 reset_n = 0;
    #1;
    outs = {m0_req_ready, m1_req_ready, dmi_req_valid, dmi_resp_ready,
            m0_resp_valid, m1_resp_valid, busy};
    fields = {dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data, m0_resp_bits_resp,
              m0_resp_bits_data, m1_resp_bits_resp, m1_resp_bits_data};
    n_checks++;
    if (outs !== 7'b0 || fields !== '0) begin
      n_fail++; $display("FAIL async_reset: got outs=%b f=%0h expected 0 0", outs, fields);
    end
    cyc();
    reset_n = 1;
    model_last = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m1_req_ready, m0_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL post_reset_tie: got %b expected 01", {m1_req_ready, m0_req_ready});
    end
    model_last = 1'b0;
    cyc();
    m0_req_valid = 0; m1_req_valid = 0; dmi_req_ready = 1;
    cyc();
    dmi_req_ready = 0; dmi_resp_valid = 1; dmi_resp_bits_data = 32'h5A5A0F0F;
    cyc();
    dmi_resp_valid = 0; m0_resp_ready = 1; m1_resp_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({m1_resp_valid, m0_resp_valid, m0_resp_bits_data} !== {2'b01, 32'h5A5A0F0F}) begin
      n_fail++; $display("FAIL post_reset_resp: got v=%b d=%h expected 01 d=5a5a0f0f",
                         {m1_resp_valid, m0_resp_valid}, m0_resp_bits_data);
    end
    cyc();
    clear_inputs();
    cyc();
  endtask

  task automatic test_random();
    bit v0, v1, e0, e1, exp_idx;
    logic [1:0]  dis, rc;
    logic [40:0] ef;
    logic [31:0] rd;
    int st, lat, hold;
    for (int t = 0; t < 40; t++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); dis = 2'($urandom);
      if (t % 4 == 0) dis = 2'b00;
      m0_req_valid = v0; m1_req_valid = v1; m_disable = dis;
      rand_reqs();
      e0 = v0 && !dis[0];
      e1 = v1 && !dis[1];
      exp_idx = (e0 && e1) ? ~model_last : e1;
      @(negedge clk);
      n_checks++;
      if ({m1_req_ready, m0_req_ready} !== (!(e0 || e1) ? 2'b00 : (exp_idx ? 2'b10 : 2'b01))) begin
        n_fail++; $display("FAIL rnd_grant%0d: got %b for v=%b%b dis=%b last=%0d", t,
                           {m1_req_ready, m0_req_ready}, v1, v0, dis, model_last);
      end
      if (!(e0 || e1)) begin
        cyc();
        clear_inputs();
        continue;
      end
      model_last = exp_idx;
      ef = exp_idx ? {m1_req_bits_addr, m1_req_bits_op, m1_req_bits_data}
                   : {m0_req_bits_addr, m0_req_bits_op, m0_req_bits_data};
      cyc();
      m0_req_valid = 0; m1_req_valid = 0; m_disable = 2'($urandom);
      st = $urandom_range(0, 3);
      repeat (st) cyc();
      dmi_req_ready = 1;
      @(negedge clk);
      n_checks++;
      if ({dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data} !== {1'b1, ef}) begin
        n_fail++; $display("FAIL rnd_issue%0d: got v=%b f=%0h expected v=1 f=%0h", t, dmi_req_valid,
                           {dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data}, ef);
      end
      cyc();
      dmi_req_ready = 0;
      lat = $urandom_range(0, 4);
      repeat (lat) cyc();
      rc = 2'($urandom_range(0, 2));
      if (rc == 2'd1) rc = RESP_BUSY;
      rd = $urandom;
      dmi_resp_valid = 1; dmi_resp_bits_resp = rc; dmi_resp_bits_data = rd;
      cyc();
      dmi_resp_valid = 0;
      hold = $urandom_range(0, 2);
      for (int h = 0; h <= hold; h++) begin
        if (h == hold) begin
          if (exp_idx) m1_resp_ready = 1; else m0_resp_ready = 1;
        end
        @(negedge clk);
        n_checks++;
        if ({m1_resp_valid, m0_resp_valid} !== (exp_idx ? 2'b10 : 2'b01) ||
            (exp_idx ? {m1_resp_bits_resp, m1_resp_bits_data}
                     : {m0_resp_bits_resp, m0_resp_bits_data}) !== {rc, rd}) begin
          n_fail++; $display("FAIL rnd_resp%0d: got v=%b r0=%0d d0=%h r1=%0d d1=%h expected m%0d r=%0d d=%h",
                             t, {m1_resp_valid, m0_resp_valid}, m0_resp_bits_resp, m0_resp_bits_data,
                             m1_resp_bits_resp, m1_resp_bits_data, exp_idx, rc, rd);
        end
        cyc();
      end
      clear_inputs();
    end
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    clear_inputs();
    model_last = 1'b1;
    test_reset();
    test_single_read();
    test_tie();
    test_backpressure();
    test_timeout();
    test_disable_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 1024, cycles WAIT tolerates without a downstream response; 0 disables the timeout.
REQ-002 Port: clk  in  1  single clock; all logic on posedge clk.
REQ-003 Port: reset_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: m0_req_valid / m1_req_valid  in  1  requester N offers a DMI request.
REQ-005 Port: m0_req_ready / m1_req_ready  out  1  request of requester N accepted this cycle.
REQ-006 Port: m0_req_bits_addr / m1_req_bits_addr  in  7  DMI address.
REQ-007 Port: m0_req_bits_op / m1_req_bits_op  in  2  DMI op.
REQ-008 Port: m0_req_bits_data / m1_req_bits_data  in  32  DMI write data.
REQ-009 Port: m0_resp_valid / m1_resp_valid  out  1  response for requester N.
REQ-010 Port: m0_resp_ready / m1_resp_ready  in  1  requester N accepts the response.
REQ-011 Port: m0_resp_bits_resp / m1_resp_bits_resp  out  2  DMI response code.
REQ-012 Port: m0_resp_bits_data / m1_resp_bits_data  out  32  DMI read data.
REQ-013 Port: m_disable  in  2  bit N set means requester N is never granted.
REQ-014 Port: dmi_req_valid / dmi_req_ready  out / in  1 / 1  downstream request handshake.
REQ-015 Port: dmi_req_bits_addr / dmi_req_bits_op / dmi_req_bits_data  out  7 / 2 / 32  downstream request fields.
REQ-016 Port: dmi_resp_valid / dmi_resp_ready  in / out  1 / 1  downstream response handshake.
REQ-017 Port: dmi_resp_bits_resp / dmi_resp_bits_data  in  2 / 32  downstream response fields.
REQ-018 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The arbiter SHALL have states IDLE, ISSUE, WAIT, RETURN and DRAIN, and SHALL keep at most one transaction outstanding.
REQ-020 In IDLE, a requester SHALL be eligible when req_valid=1 and its m_disable bit=0.
- Exactly one eligible requester: that requester is granted.
- Both eligible: the requester not granted last is granted (round-robin).
REQ-021 In IDLE, the granted requester's req_ready SHALL be driven high combinationally in that cycle.
- The arbiter registers addr, op and data, records the owner, updates the last-grant pointer, and moves to ISSUE.
- The non-granted requester's req_ready stays 0.
REQ-022 In ISSUE, dmi_req_valid SHALL be 1 with the registered fields held stable until dmi_req_ready=1; the handshake cycle moves the state to WAIT and clears the timeout counter.
REQ-023 Latency: a request accepted in cycle N SHALL present dmi_req_valid=1 in cycle N+1.
REQ-024 dmi_resp_ready SHALL be 1 only in WAIT and DRAIN; a dmi_resp_valid seen in IDLE, ISSUE or RETURN SHALL be ignored.
REQ-025 In WAIT, dmi_resp_valid=1 SHALL capture resp and data and move the state to RETURN; the owner's resp_valid rises on the next cycle.
REQ-026 Timeout in WAIT: when TIMEOUT>0 and the counter reaches TIMEOUT-1 with no response, the arbiter SHALL load resp=FAILED (2'b10), data=0, set drain_pending, and move to RETURN.
REQ-027 In RETURN, only the owner's resp_valid SHALL be 1, held with stable fields until its resp_ready=1.
- Next state on that handshake: DRAIN if drain_pending, else IDLE.
REQ-028 DRAIN SHALL accept and discard exactly one downstream response, then clear drain_pending and return to IDLE.
REQ-029 An m_disable change SHALL affect only future grants and SHALL never abort an owned transaction.
REQ-030 The timeout counter SHALL saturate and be 0 outside WAIT.

Reset
REQ-031 While reset_n=0, the arbiter SHALL hold:
- state=IDLE, last-grant=m1 (so m0 wins the first tie), drain_pending=0, counter=0;
- all data and field registers at 0;
- every valid and ready output at 0, and busy=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction immediately; no response is returned to the requester.

Structure
REQ-033 Package dmi_arb_pkg SHALL hold the shared definitions:
- DMI widths: addr 7, op 2, data 32, resp 2;
- op codes: NOP=0, READ=1, WRITE=2;
- resp codes: SUCCESS=0, FAILED=2, BUSY=3;
- the state enum.
REQ-034 A single sub-module, dmi_rr_grant, SHALL implement the 2-way round-robin pick from the eligible vector and the last-grant pointer.

Verification
REQ-035 Single read: m0 READ addr=0x11; downstream answers 2 cycles after the handshake with resp=0, data=0xCAFE0001 -> m0 gets resp=0, data=0xCAFE0001; m1_resp_valid stays 0.
REQ-036 Tie: both requesters valid from reset, downstream zero-latency -> grants alternate m0, m1, m0, m1; the dmi addr sequence matches.
REQ-037 Backpressure: dmi_req_ready=0 for 5 cycles -> dmi_req fields are stable all 5 cycles and no second request is accepted.
REQ-038 Timeout: TIMEOUT=8, no response -> owner gets resp=2, data=0 9 cycles after the handshake; a late response (data=0x1234) is discarded in DRAIN and the next transaction completes normally.
REQ-039 Disable/reset: m_disable=2'b01 with both valid -> only m1 is granted; reset_n pulsed low in WAIT -> all outputs 0 and state IDLE at once.
